// File: rtl/ibex_ahb_master_arbiter_if.sv
// ibex_ahb_master_arbiter_if: Ibex instruction/data ports plus the AHB-Lite master bus.
interface ibex_ahb_master_arbiter_if;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE, HREADY, HRESP;
  modport master (
    input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
           HRDATA, HREADY, HRESP,
    output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
           data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
           HADDR, HTRANS, HSIZE, HBURST, HWRITE, HPROT, HWDATA
  );
  modport slave (
    output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
           HRDATA, HREADY, HRESP,
    input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
           data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
           HADDR, HTRANS, HSIZE, HBURST, HWRITE, HPROT, HWDATA
  );
endinterface

// File: rtl/ibex_ahb_master_arbiter.sv
// ibex_ahb_master_arbiter: arbitrates Ibex instr/data ports onto one pipelined AHB-Lite master.
module ibex_ahb_master_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  ibex_ahb_master_arbiter_if.master  bus
);
  typedef enum logic [1:0] {IDLE, DPH_I, DPH_D} state_e;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_e      state_q;
  logic [3:0]  starve_q, hprot_q;
  logic        held_q, held_own_q, hwrite_q;
  logic [31:0] haddr_q, hwdata_q, addr_c;
  logic [2:0]  hsize_q, size_c, dsize_c;
  logic [1:0]  off_c;
  logic        held_ok, own_d, active, accept, starved;
  always_comb begin
    dsize_c = 3'b010;
    off_c   = 2'b00;
    case (bus.data_be_i)
      4'b0011: dsize_c = 3'b001;
      4'b1100: {dsize_c, off_c} = {3'b001, 2'b10};
      4'b0001: dsize_c = 3'b000;
      4'b0010: {dsize_c, off_c} = {3'b000, 2'b01};
      4'b0100: {dsize_c, off_c} = {3'b000, 2'b10};
      4'b1000: {dsize_c, off_c} = {3'b000, 2'b11};
      default: ;
    endcase
  end
  // A stalled address phase keeps its owner as long as that owner is still requesting
  assign starved = bus.instr_req_i && starve_q == SMAX;
  assign held_ok = held_q && (held_own_q ? bus.data_req_i : bus.instr_req_i);
  assign own_d   = held_ok ? held_own_q : bus.data_req_i && !starved;
  assign active  = rst_ni && (bus.instr_req_i || bus.data_req_i);
  assign accept  = active && bus.HREADY;
  assign addr_c  = own_d ? {bus.data_addr_i[31:2], off_c} : {bus.instr_addr_i[31:2], 2'b00};
  assign size_c  = own_d ? dsize_c : 3'b010;
  assign bus.HTRANS = active ? 2'b10 : 2'b00;
  assign bus.HADDR  = active ? addr_c : haddr_q;
  assign bus.HSIZE  = active ? size_c : hsize_q;
  assign bus.HWRITE = active ? own_d && bus.data_we_i : hwrite_q;
  assign bus.HPROT  = active ? {3'b001, own_d} : hprot_q;
  assign bus.HBURST = 3'b000;
  assign bus.HWDATA = hwdata_q;
  assign bus.instr_gnt_o    = accept && !own_d;
  assign bus.data_gnt_o     = accept && own_d;
  assign bus.instr_rvalid_o = state_q == DPH_I && bus.HREADY;
  assign bus.data_rvalid_o  = state_q == DPH_D && bus.HREADY;
  assign bus.instr_err_o    = bus.instr_rvalid_o && bus.HRESP;
  assign bus.data_err_o     = bus.data_rvalid_o && bus.HRESP;
  assign bus.instr_rdata_o  = bus.HRDATA;
  assign bus.data_rdata_o   = bus.HRDATA;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      held_q     <= 1'b0;
      held_own_q <= 1'b0;
      haddr_q    <= '0;
      hsize_q    <= 3'b010;
      hwrite_q   <= 1'b0;
      hprot_q    <= 4'b0010;
      hwdata_q   <= '0;
    end else begin
      held_q     <= active && !bus.HREADY;
      held_own_q <= own_d;
      if (active) begin
        haddr_q  <= addr_c;
        hsize_q  <= size_c;
        hwrite_q <= own_d && bus.data_we_i;
        hprot_q  <= {3'b001, own_d};
      end
      if (bus.data_gnt_o) hwdata_q <= bus.data_wdata_i;
      starve_q <= (!bus.instr_req_i || bus.instr_gnt_o) ? 4'd0 :
                  (bus.data_gnt_o && starve_q != SMAX) ? starve_q + 4'd1 : starve_q;
      if (bus.HREADY) state_q <= !accept ? IDLE : own_d ? DPH_D : DPH_I;
    end
  end
endmodule
